// File: rtl/rcon_seq.sv
// AES key-schedule word sequencer: walks word index i from Nk to 4*Nk+27 and
// emits per-word transform descriptors, generating Rcon by GF(2^8) doubling.
module rcon_seq #(
  parameter int unsigned           DATA_W    = 8,
  parameter logic [DATA_W-1:0]     POLY      = 8'h1B,
  parameter logic [DATA_W-1:0]     RCON_INIT = 8'h01,
  parameter int unsigned           IDX_W     = 6
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [1:0]        nk_in,
  input  logic              ready_in,
  output logic              valid_out,
  output logic [IDX_W-1:0]  idx_out,
  output logic [DATA_W-1:0] rcon_out,
  output logic              rot_sub_out,
  output logic              sub_only_out,
  output logic              last_out,
  output logic              busy_out,
  output logic              done_out
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [3:0]         nk_q, nk_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [2:0]         phase_q, phase_d;
  logic [DATA_W-1:0]  rcon_q, rcon_d;

  // Output registers, loaded from next-state so descriptors line up with state.
  logic               valid_q;
  logic [IDX_W-1:0]   idx_o_q;
  logic [DATA_W-1:0]  rcon_o_q;
  logic               rot_sub_q, sub_only_q, last_q, done_q;

  logic [3:0]         nk_sel;
  logic [DATA_W-1:0]  rcon_x2;
  logic               run_d;
  logic [IDX_W-1:0]   last_idx_d;

  always_comb begin
    unique case (nk_in)
      2'd1:    nk_sel = 4'd6;
      2'd2:    nk_sel = 4'd8;
      default: nk_sel = 4'd4;
    endcase
  end

  assign rcon_x2 = {rcon_q[DATA_W-2:0], 1'b0} ^ (rcon_q[DATA_W-1] ? POLY : '0);

  always_comb begin
    state_d = state_q;
    nk_d    = nk_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    rcon_d  = rcon_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (state_q == StDone) state_d = StIdle;
        if (start_in) begin
          state_d = StRun;
          nk_d    = nk_sel;
          idx_d   = IDX_W'(nk_sel);
          phase_d = '0;
          rcon_d  = RCON_INIT;
        end
      end
      StRun: begin
        if (ready_in) begin
          if (last_q) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            phase_d = ({1'b0, phase_q} == nk_q - 4'd1) ? '0 : phase_q + 3'd1;
            if (phase_q == '0) rcon_d = rcon_x2;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign run_d      = (state_d == StRun);
  assign last_idx_d = IDX_W'({nk_d, 2'b00}) + IDX_W'(27);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      nk_q       <= '0;
      idx_q      <= '0;
      phase_q    <= '0;
      rcon_q     <= RCON_INIT;
      valid_q    <= 1'b0;
      idx_o_q    <= '0;
      rcon_o_q   <= '0;
      rot_sub_q  <= 1'b0;
      sub_only_q <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      nk_q       <= nk_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      rcon_q     <= rcon_d;
      valid_q    <= run_d;
      idx_o_q    <= run_d ? idx_d : '0;
      rcon_o_q   <= (run_d && phase_d == '0) ? rcon_d : '0;
      rot_sub_q  <= run_d && (phase_d == '0);
      sub_only_q <= run_d && (nk_d == 4'd8) && (phase_d == 3'd4);
      last_q     <= run_d && (idx_d == last_idx_d);
      done_q     <= (state_d == StDone);
    end
  end

  assign valid_out    = valid_q;
  assign busy_out     = valid_q;
  assign idx_out      = idx_o_q;
  assign rcon_out     = rcon_o_q;
  assign rot_sub_out  = rot_sub_q;
  assign sub_only_out = sub_only_q;
  assign last_out     = last_q;
  assign done_out     = done_q;

endmodule

// File: tb/tb_rcon_seq.sv
// Self-checking bench for rcon_seq against an arithmetic model of the AES key schedule.
module tb_rcon_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic [1:0] nk = 2'd0;
  logic       valid, rot_sub, sub_only, last, busy, done;
  logic [5:0] idx;
  logic [7:0] rcon;

  int n_tests = 0;
  int n_fail  = 0;

  rcon_seq dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .start_in    (start),
    .nk_in       (nk),
    .ready_in    (ready),
    .valid_out   (valid),
    .idx_out     (idx),
    .rcon_out    (rcon),
    .rot_sub_out (rot_sub),
    .sub_only_out(sub_only),
    .last_out    (last),
    .busy_out    (busy),
    .done_out    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int xt(input int r);
    return ((r << 1) ^ (((r & 'h80) != 0) ? 'h11B : 0)) & 'hFF;
  endfunction

  task automatic chk_idle(input string tag, input bit exp_done);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_idx"}, 32'(idx), 0);
    chk({tag, "_rcon"}, 32'(rcon), 0);
    chk({tag, "_rotsub"}, 32'(rot_sub), 0);
    chk({tag, "_subonly"}, 32'(sub_only), 0);
    chk({tag, "_last"}, 32'(last), 0);
  endtask

  // Expected descriptor for word i from the key-schedule rules directly.
  task automatic chk_word(input int nkv, input int i);
    string t;
    int    rc;
    bit    rs, so, ls;
    t  = $sformatf("nk%0d_i%0d", nkv, i);
    rs = (i % nkv) == 0;
    rc = 0;
    if (rs) begin
      rc = 1;
      for (int r = 1; r < i / nkv; r++) rc = xt(rc);
    end
    so = (nkv == 8) && ((i % 8) == 4);
    ls = (i == 4 * nkv + 27);
    chk({t, "_valid"}, 32'(valid), 1);
    chk({t, "_busy"}, 32'(busy), 1);
    chk({t, "_done"}, 32'(done), 0);
    chk({t, "_idx"}, 32'(idx), i);
    chk({t, "_rotsub"}, 32'(rot_sub), 32'(rs));
    chk({t, "_rcon"}, 32'(rcon), rc);
    chk({t, "_subonly"}, 32'(sub_only), 32'(so));
    chk({t, "_last"}, 32'(last), 32'(ls));
  endtask

  task automatic run_seq(input int code, input bit stall, input bit started,
                         input bit restart, input int rcode);
    int nkv;
    int stalls;
    nkv = (code == 1) ? 6 : (code == 2) ? 8 : 4;
    if (!started) begin
      @(negedge clk);
      start = 1'b1;
      nk    = 2'(code);
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    nk    = 2'($urandom);
    for (int i = nkv; i <= 4 * nkv + 27; i++) begin
      chk_word(nkv, i);
      if (stall) begin
        ready = ($urandom_range(0, 2) != 0);
        start = 1'($urandom);
        nk    = 2'($urandom);
      end else begin
        ready = 1'b1;
      end
      stalls = 0;
      while (!ready) begin
        @(posedge clk);
        @(negedge clk);
        chk_word(nkv, i);
        stalls++;
        ready = (stalls >= 6) || ($urandom_range(0, 1) != 0);
        start = 1'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk_idle($sformatf("nk%0d_donecyc", nkv), 1'b1);
    start = restart;
    nk    = 2'(rcode);
    if (!restart) begin
      @(posedge clk);
      @(negedge clk);
      chk_idle($sformatf("nk%0d_after", nkv), 1'b0);
    end
  endtask

  initial begin
    int guard;
    repeat (2) @(negedge clk);
    chk_idle("in_reset", 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_reset", 1'b0);

    run_seq(0, 1'b0, 1'b0, 1'b0, 0);
    run_seq(1, 1'b0, 1'b0, 1'b0, 0);
    run_seq(2, 1'b0, 1'b0, 1'b0, 0);
    run_seq(0, 1'b1, 1'b0, 1'b0, 0);

    // Mid-run asynchronous reset, then a fresh Nk=8 run.
    @(negedge clk);
    start = 1'b1;
    nk    = 2'd1;
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (idx != 6'd20 && guard < 100) begin
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    chk("reach_idx20", 32'(idx), 20);
    rst = 1'b1;
    #1;
    chk_idle("async_rst", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    chk_idle("async_rst_hold", 1'b0);
    run_seq(2, 1'b0, 1'b0, 1'b0, 0);

    // nk_in = 3 acts as Nk=4; restart issued during the done cycle.
    run_seq(3, 1'b0, 1'b0, 1'b1, 0);
    run_seq(0, 1'b0, 1'b1, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rcon_seq.md
# rcon_seq

Sequential AES round-constant generator and key-schedule word sequencer. It computes Rcon on the fly by GF(2^8) doubling (xtime) instead of a ROM lookup, and supports all three AES key lengths (Nk = 4/6/8). It walks the expanded-key word index i from Nk up to 4·(Nr+1)−1. For each word it tells the key-expansion datapath which transform to apply, using a valid/ready handshake.

## Interface

Parameters:
- DATA_W, 8, Rcon field width in bits.
- POLY, 8'h1B, low DATA_W bits of the reduction polynomial, XORed in on MSB carry-out.
- RCON_INIT, 8'h01, first Rcon value.
- IDX_W, 6, word-index width; must be ≥ 6 so that index 59 fits.

Ports:
- clk_in, input, 1, single clock; all state changes on its rising edge.
- rst_in, input, 1, asynchronous, active-high reset.
- start_in, input, 1, begins a sequence; sampled only while busy_out = 0.
- nk_in, input, 2, key length, sampled with start_in: 0 → Nk=4, 1 → Nk=6, 2 → Nk=8, 3 → treated as Nk=4.
- ready_in, input, 1, consumer accepts the current word.
- valid_out, output, 1, current word descriptor valid.
- idx_out, output, IDX_W, word index i.
- rcon_out, output, DATA_W, Rcon byte when rot_sub_out = 1, else 0.
- rot_sub_out, output, 1, i mod Nk == 0: apply RotWord, SubWord and XOR Rcon.
- sub_only_out, output, 1, Nk = 8 and i mod 8 == 4: apply SubWord only.
- last_out, output, 1, i == 4·Nk + 27, the final word.
- busy_out, output, 1, high in RUN.
- done_out, output, 1, one-cycle pulse after the last word transfers.

## Operation

- FSM states: IDLE, RUN, DONE.
  - IDLE: on start_in, latch Nk, set i = Nk, phase = 0, rcon = RCON_INIT, then go to RUN.
  - RUN: valid_out = 1. A transfer occurs on valid_out && ready_in.
    - On a non-last transfer: i += 1; phase = (phase == Nk−1) ? 0 : phase+1. If the old phase was 0, rcon updates to xtime(rcon).
    - On a last transfer: go to DONE.
  - DONE: done_out = 1 for exactly one cycle, then go to IDLE. A start_in in DONE is accepted as it is in IDLE; done_out still pulses in that cycle.
- xtime(r) = {r[DATA_W−2:0], 1'b0} ^ (r[DATA_W−1] ? POLY : 0), truncated to DATA_W.
- Final index is 4·Nk + 27: 43, 51 or 59.
- start_in in RUN is ignored. nk_in is ignored except when sampled with start_in.
- The descriptor outputs (idx_out, rcon_out, rot_sub_out, sub_only_out, last_out) are registered. They are stable while valid_out && !ready_in.
- The phase counter is never computed with a divider; it wraps at Nk−1.

## Timing

- Reset value of every output is 0. Internal state resets to IDLE, i = 0, phase = 0, rcon = RCON_INIT.
- Asserting rst_in mid-sequence forces all outputs to 0 immediately, asynchronously. No done_out pulse is produced.
- Start latency: start_in sampled at edge N gives valid_out = 1 with idx_out = Nk after edge N.
- Throughput: with ready_in held high, one word per cycle with no bubbles. A full Nk=4 sequence is 40 transfer cycles.
- Last-word timing: the last transfer at edge M drops valid_out and raises done_out after edge M. done_out falls after edge M+1, and busy_out falls after edge M.
- Back-pressure: ready_in low holds all outputs and state. There is no combinational path from ready_in to any output.

## Test plan

- Nk=4, ready_in held high: rot_sub_out at i = 4, 8, …, 40. rcon_out across those words = 01,02,04,08,10,20,40,80,1B,36. last_out at idx 43. done_out one cycle later.
- Nk=6: rot_sub_out at i = 6, 12, …, 48 with rcon_out = 01..80 (8 values). sub_only_out never asserts. last_out at idx 51.
- Nk=8: rot_sub_out at i = 8, 16, …, 56 with rcon_out = 01..40. sub_only_out at i = 12, 20, …, 52. last_out at idx 59.
- Random ready_in stalls on an Nk=4 run: outputs stay frozen during stalls. The transferred sequence is identical to the unstalled run, and start_in pulses during RUN have no effect.
- Assert rst_in at idx 20 of an Nk=6 run: all outputs read 0 at once. A new start with nk_in = 2 begins at idx 8 with rcon_out = 01.
- nk_in = 3 behaves exactly as Nk=4. A start_in in the DONE cycle restarts the sequence with valid_out high on the next cycle.
